// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: FSM state encoding and frame length.
// Used by the serial-out transmitter and the matching serial-in receiver.
package serial_link_pkg;

    // Link FSM states; encoding is shared with the receiver.
    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } link_state_e;

    // Number of bits on the wire per word: data bits plus an optional parity bit.
    function automatic int unsigned frame_len(input int unsigned width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/serial_shift_core.sv
// Loadable right-shift register with a bit counter.
// load_en has priority over shift_en. The counter wraps after the last bit,
// which also leaves the register empty, so an idle core holds zeros.
module serial_shift_core #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [Width-1:0] load_data,
    output logic             bit0,
    output logic             last
);

    localparam int unsigned   CntW    = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    logic [Width-1:0] shreg_q;
    logic [CntW-1:0]  cnt_q;

    // Capture a new word or shift out one bit per cycle, zero filling from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_en) begin
            shreg_q <= load_data;
            cnt_q   <= '0;
        end else if (shift_en) begin
            shreg_q <= {1'b0, shreg_q[Width-1:1]};
            cnt_q   <= last ? '0 : cnt_q + 1'b1;
        end
    end

    // Current bit and last-bit flag, straight from the registers.
    always_comb begin
        bit0 = shreg_q[0];
        last = (cnt_q == LastCnt);
    end

endmodule

// File: rtl/serial_out_register.sv
// Parallel-in, serial-out transmitter with a valid/ready load handshake.
// Words go out LSB first, one bit per clock, framed by sout_valid, with done
// marking the last bit of each frame.
// Optional feature: define SERIAL_OUT_PARITY_EN to append an even-parity bit
// (^D of the captured word) after the data bits.
module serial_out_register
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

`ifdef SERIAL_OUT_PARITY_EN
    localparam int unsigned Frame = frame_len(WIDTH, 1'b1);
`else
    localparam int unsigned Frame = frame_len(WIDTH, 1'b0);
`endif

    link_state_e      state_q, state_d;
    logic [Frame-1:0] load_data;
    logic             accept;
    logic             shifting;
    logic             bit0;
    logic             last;

    // Parity is computed once at accept time and rides in the top bit of the
    // shift register, so it simply falls out after the data bits.
`ifdef SERIAL_OUT_PARITY_EN
    assign load_data = {^D, D};
`else
    assign load_data = D;
`endif

    // Handshake: ready depends only on registered state, never on load.
    always_comb begin
        shifting = (state_q == StShift);
        ready    = (state_q == StIdle) || (shifting && last);
        accept   = load && ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a load on the last bit chains straight into the next frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last && !load) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    serial_shift_core #(
        .Width(Frame)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (accept),
        .shift_en (shifting),
        .load_data(load_data),
        .bit0     (bit0),
        .last     (last)
    );

    // Serial outputs are gated by state so idle and reset drive all zeros.
    always_comb begin
        sout_valid = shifting;
        sout       = shifting & bit0;
        done       = shifting & last;
    end

endmodule

// File: tb/tb_serial_out_register.sv
// Self-checking bench for serial_out_register: directed scenarios plus a
// randomized sender, all compared against a queue-of-frame-bits model.
module tb_serial_out_register;

    localparam int unsigned W = 3;
`ifdef SERIAL_OUT_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] D     = '0;
    logic         ready;
    logic         sout;
    logic         sout_valid;
    logic         done;

    int vectors     = 0;
    int miscompares = 0;

    // Model: each entry is {is_last_bit, bit} for one future sout_valid cycle.
    bit [1:0]    exp_q[$];
    logic [31:0] obs_bits;
    int          obs_len;

    serial_out_register #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .D         (D),
        .ready     (ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Bit k of the frame for word w: data LSB first, then even parity.
    function automatic bit frame_bit(input logic [W-1:0] w, input int k);
        if (k < int'(W)) return w[k];
        return ^w;
    endfunction

    // Expected {ready, sout_valid, sout, done} for the current cycle.
    function automatic logic [3:0] exp_vec();
        if (exp_q.size() == 0) return 4'b1000;
        return {(exp_q.size() == 1), 1'b1, exp_q[0][0], exp_q[0][1]};
    endfunction

    // Model update: a word is taken whenever at most its predecessor's last bit remains.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            bit rdy;
            rdy = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (load && rdy) begin
                for (int k = 0; k < F; k++) exp_q.push_back({(k == F - 1), frame_bit(D, k)});
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({ready, sout_valid, sout, done} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_idle c%0d: rvsd=%b expected 1000", c,
                         {ready, sout_valid, sout, done});
            end
        end
    endtask

    task automatic test_single(input string name, input logic [W-1:0] w, input logic [31:0] want);
        int dones = 0, done_at = -1, first_v = -1, last_v = -1;
        obs_bits = '0;
        obs_len  = 0;
        load     = 1'b1;
        D        = w;
        for (int c = 0; c < F + 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({ready, sout_valid, sout, done} !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s c%0d: rvsd=%b expected %b", name, c,
                         {ready, sout_valid, sout, done}, exp_vec());
            end
            if (sout_valid && obs_len < 32) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                obs_bits[obs_len] = sout;
                obs_len++;
            end
            if (done) begin
                dones++;
                done_at = c;
            end
            load = 1'b0;
        end
        vectors++;
        if (obs_bits !== want) begin
            miscompares++;
            $display("FAIL %s_stream: bits=%b expected %b", name, obs_bits[7:0], want[7:0]);
        end
        vectors++;
        if (first_v != 0 || last_v != F - 1 || obs_len != F) begin
            miscompares++;
            $display("FAIL %s_frame: valid cycles %0d..%0d (%0d) expected 0..%0d", name,
                     first_v, last_v, obs_len, F - 1);
        end
        vectors++;
        if (dones != 1 || done_at != F - 1) begin
            miscompares++;
            $display("FAIL %s_done: %0d pulses at c%0d expected 1 at c%0d", name, dones,
                     done_at, F - 1);
        end
    endtask

    // Hold load high; the second word is offered from the first bit cycle on and
    // must be ignored until the done cycle, then follow with no gap.
    task automatic test_back_to_back(input string name, input logic [W-1:0] w0,
                                     input logic [W-1:0] w1, input logic [31:0] want);
        int dones = 0, first_v = -1, last_v = -1;
        bit drop = 1'b0;
        obs_bits = '0;
        obs_len  = 0;
        load     = 1'b1;
        D        = w0;
        for (int c = 0; c < 2 * F + 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({ready, sout_valid, sout, done} !== exp_vec()) begin
                miscompares++;
                $display("FAIL %s c%0d: rvsd=%b expected %b", name, c,
                         {ready, sout_valid, sout, done}, exp_vec());
            end
            if (sout_valid && obs_len < 32) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                obs_bits[obs_len] = sout;
                obs_len++;
            end
            if (done) dones++;
            if (c == 0) D = w1;
            if (drop) load = 1'b0;
            else if (c > 0 && exp_q.size() <= 1) drop = 1'b1;
        end
        load = 1'b0;
        vectors++;
        if (obs_bits !== want) begin
            miscompares++;
            $display("FAIL %s_stream: bits=%b expected %b", name, obs_bits[7:0], want[7:0]);
        end
        vectors++;
        if (obs_len != 2 * F || last_v - first_v + 1 != obs_len) begin
            miscompares++;
            $display("FAIL %s_gapless: valid cycles %0d..%0d (%0d) expected %0d contiguous",
                     name, first_v, last_v, obs_len, 2 * F);
        end
        vectors++;
        if (dones != 2) begin
            miscompares++;
            $display("FAIL %s_done: %0d pulses expected 2", name, dones);
        end
    endtask

    task automatic test_reset_mid_frame(input logic [31:0] want);
        load = 1'b1;
        D    = 3'b111;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        vectors++;
        if (!sout_valid) begin
            miscompares++;
            $display("FAIL midreset_pre: sout_valid=%b expected 1", sout_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ready, sout_valid, sout, done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_async: rvsd=%b expected 1000",
                     {ready, sout_valid, sout, done});
        end
        @(negedge clk);
        vectors++;
        if ({ready, sout_valid, sout, done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_held: rvsd=%b expected 1000",
                     {ready, sout_valid, sout, done});
        end
        rst_n = 1'b1;
        @(negedge clk);
        test_single("after_reset", 3'b111, want);
    endtask

    // Random words with random idle gaps (including none); load held until taken.
    task automatic test_random(input int n_words);
        int  idx = 0, gap = 0;
        bit  accepting = 1'b0;
        load = 1'b0;
        for (int c = 0; c < 2000 && idx < n_words; c++) begin
            @(negedge clk);
            vectors++;
            if ({ready, sout_valid, sout, done} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random c%0d: rvsd=%b expected %b", c,
                         {ready, sout_valid, sout, done}, exp_vec());
            end
            if (accepting) begin
                idx++;
                accepting = 1'b0;
                load = 1'b0;
                gap = int'($urandom_range(0, 3));
            end
            if (!load && idx < n_words) begin
                if (gap == 0) begin
                    load = 1'b1;
                    D    = W'($urandom);
                end else begin
                    gap--;
                end
            end
            if (load && exp_q.size() <= 1) accepting = 1'b1;
        end
        load = 1'b0;
        vectors++;
        if (idx != n_words) begin
            miscompares++;
            $display("FAIL random_progress: %0d words sent expected %0d", idx, n_words);
        end
        for (int c = 0; c < F + 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({ready, sout_valid, sout, done} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_drain c%0d: rvsd=%b expected %b", c,
                         {ready, sout_valid, sout, done}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef SERIAL_OUT_PARITY_EN
        test_single("single_101", 3'b101, 32'b0101);
        test_single("single_001", 3'b001, 32'b1001);
        test_single("single_011", 3'b011, 32'b0011);
        test_back_to_back("back_to_back", 3'b110, 3'b011, 32'b00110110);
        test_back_to_back("busy_ignore", 3'b100, 3'b111, 32'b11111100);
        test_reset_mid_frame(32'b1111);
`else
        test_single("single_101", 3'b101, 32'b101);
        test_single("single_001", 3'b001, 32'b001);
        test_single("single_011", 3'b011, 32'b011);
        test_back_to_back("back_to_back", 3'b110, 3'b011, 32'b011110);
        test_back_to_back("busy_ignore", 3'b100, 3'b111, 32'b111100);
        test_reset_mid_frame(32'b111);
`endif
        test_random(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
